// File: rtl/sdram_burst_reader.sv
// ============================================================================
//  Module   : sdram_burst_reader
//  Purpose  : Avalon-MM burst-read DMA master that splits a (word address, beat count)
//             command into bursts. A burst is issued only when the read-data
//             FIFO has room for every beat still in flight. Data leaves in
//             order on a valid/ready stream.
//  Options  : SDRAM_RD_PERF_EN adds the perf_beats / perf_stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_burst_reader #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int BURST_W    = 8,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 20
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_beats,
    output logic [ADDR_W-1:0]  avm_address,
    output logic [BURST_W-1:0] avm_burstcount,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               st_valid,
    input  logic               st_ready,
    output logic [DATA_W-1:0]  st_data,
    output logic               busy,
    output logic               done
`ifdef SDRAM_RD_PERF_EN
    ,
    output logic [31:0]        perf_beats,
    output logic [31:0]        perf_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   r_total;
    logic [LEN_W-1:0]   r_received;
    logic [LEN_W-1:0]   r_popped;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_avm_read;
    logic [ADDR_W-1:0]  r_avm_address;
    logic [BURST_W-1:0] r_avm_burstcount;
    logic               r_busy;
    logic               r_done;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept_cmd;
    logic               w_burst_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_last_pop;
    logic               w_issue_nxt;
    logic [LEN_W-1:0]   w_rem_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [CNT_W-1:0]   w_out_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_b_nxt;
    logic [CNT_W-1:0]   w_credit_nxt;

    assign cmd_ready      = (r_state == ST_IDLE);
    assign avm_read       = r_avm_read;
    assign avm_address    = r_avm_address;
    assign avm_burstcount = r_avm_burstcount;
    assign busy           = r_busy;
    assign done           = r_done;
    assign st_valid       = (r_count != '0);
    assign st_data        = st_valid ? r_mem[r_rd_ptr] : '0;

    assign w_accept_cmd = cmd_valid && (r_state == ST_IDLE);
    assign w_burst_acc  = r_avm_read && !avm_waitrequest;
    // Return beats seen in IDLE belong to an aborted transfer and are dropped.
    assign w_push       = avm_readdatavalid && (r_state != ST_IDLE);
    assign w_pop        = st_valid && st_ready;
    assign w_last_pop   = w_pop && (r_state == ST_DRAIN) &&
                          ((r_popped + LEN_W'(1)) == r_total);

    // Credit and burst length are evaluated on next-cycle values so a new
    // burst can follow an accepted one without a gap.
    always_comb begin
        w_rem_nxt  = r_remaining;
        w_addr_nxt = r_addr;
        w_out_nxt  = r_outstanding - CNT_W'(w_push);
        if (w_accept_cmd) begin
            w_rem_nxt  = cmd_beats;
            w_addr_nxt = cmd_addr;
            w_out_nxt  = '0;
        end else if (w_burst_acc) begin
            w_rem_nxt  = r_remaining - LEN_W'(r_avm_burstcount);
            w_addr_nxt = r_addr + ADDR_W'(r_avm_burstcount);
            w_out_nxt  = r_outstanding + CNT_W'(r_avm_burstcount) - CNT_W'(w_push);
        end
        w_cnt_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_b_nxt      = (w_rem_nxt > c_max_len) ? c_max_len : w_rem_nxt;
        w_credit_nxt = c_depth - w_cnt_nxt - w_out_nxt;
        w_issue_nxt  = (w_accept_cmd || (r_state == ST_ISSUE)) &&
                       (w_rem_nxt != '0) &&
                       (LEN_W'(w_credit_nxt) >= w_b_nxt);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state          <= ST_IDLE;
            r_addr           <= '0;
            r_remaining      <= '0;
            r_total          <= '0;
            r_received       <= '0;
            r_popped         <= '0;
            r_outstanding    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_address    <= '0;
            r_avm_burstcount <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
        end else begin
            r_done        <= 1'b0;
            r_addr        <= w_addr_nxt;
            r_remaining   <= w_rem_nxt;
            r_outstanding <= w_out_nxt;
            r_count       <= w_cnt_nxt;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_received <= r_received + LEN_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_popped <= r_popped + LEN_W'(1);
            end
            // Request fields stay frozen while the slave stalls.
            if (!(r_avm_read && avm_waitrequest)) begin
                r_avm_read       <= w_issue_nxt;
                r_avm_address    <= w_addr_nxt;
                r_avm_burstcount <= BURST_W'(w_b_nxt);
            end
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_total    <= cmd_beats;
                        r_received <= '0;
                        r_popped   <= '0;
                        if (cmd_beats != '0) begin
                            r_state <= ST_ISSUE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_burst_acc && (w_rem_nxt == '0)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= avm_readdata;
        end
    end

`ifdef SDRAM_RD_PERF_EN
    logic [31:0] r_perf_beats;
    logic [31:0] r_perf_stall;
    logic        w_stall_cyc;

    assign w_stall_cyc = (r_avm_read && avm_waitrequest) ||
                         ((r_state == ST_ISSUE) && !r_avm_read);
    assign perf_beats  = r_perf_beats;
    assign perf_stall  = r_perf_stall;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_accept_cmd) begin
            r_perf_beats <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push && (r_perf_beats != '1)) begin
                r_perf_beats <= r_perf_beats + 32'd1;
            end
            if (w_stall_cyc && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end
`endif

    a_fifo_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
        !(w_push && (r_count == c_depth)));
    a_no_extra_beats: assert property (@(posedge sys_clk) disable iff (sys_rst)
        !(w_push && (r_received == r_total)));

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_reader.sv
// ============================================================================
//  Module   : tb_sdram_burst_reader
//  Purpose  : Scoreboard bench for sdram_burst_reader with a randomised Avalon
//             slave and stream sink. Reads SDRAM_RD_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_burst_reader;

    logic         clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [27:0]  cmd_addr = '0;
    logic [19:0]  cmd_beats = '0;
    logic [27:0]  avm_address;
    logic [7:0]   avm_burstcount;
    logic         avm_read;
    logic         avm_waitrequest = 1'b0;
    logic [127:0] avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;
    logic         st_valid;
    logic         st_ready = 1'b0;
    logic [127:0] st_data;
    logic         busy;
    logic         done;
`ifdef SDRAM_RD_PERF_EN
    logic [31:0]  perf_beats;
    logic [31:0]  perf_stall;
`endif

    sdram_burst_reader dut (
        .sys_clk           (clk),
        .sys_rst           (sys_rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_beats         (cmd_beats),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_data           (st_data),
        .busy              (busy),
`ifdef SDRAM_RD_PERF_EN
        .perf_beats        (perf_beats),
        .perf_stall        (perf_stall),
`endif
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Controls written by the main sequence only.
    int          req_seq = 0;
    int          rst_seq = 0;
    logic [27:0] req_addr = '0;
    logic [19:0] req_beats = '0;
    int          rdy_mode = 0;
    bit          wr_rand = 0;
    bit          rdv_rand = 0;
    bit          stall_arm = 0;
    bit          zw = 0;

    // Status written by the monitor only.
    int cyc = 0;
    int n_bursts = 0;
    int done_cnt = 0;
    int rx_count = 0;
    int pop_beats = 0;
    int zw_cnt = 0;
    int stall_seen = 0;

    logic [127:0] exp_data[$];
    logic [35:0]  exp_bursts[$];
    logic [27:0]  pending[$];

    function automatic logic [127:0] word_of(input logic [27:0] a);
        return {4'h0, a, 4'h1, ~a, 32'hC0FFEE00 ^ {4'h0, a}, 4'h3, a};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: full beat sequence and the burst split of a command.
    task automatic model_cmd(input logic [27:0] a0, input logic [19:0] n);
        logic [27:0] a;
        int rem;
        int b;
        a = a0;
        rem = int'(n);
        for (int i = 0; i < int'(n); i++) exp_data.push_back(word_of(a0 + 28'(i)));
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            exp_bursts.push_back({a, 8'(b)});
            a = a + 28'(b);
            rem -= b;
        end
    endtask

    // Monitor: Avalon slave, stream sink, command driver and scoreboard.
    initial begin
        int          req_served;
        int          rst_served;
        bit          rst_check;
        bit          presenting;
        logic [27:0] snap_addr;
        logic [7:0]  snap_bc;
        int          stall;
        int          hold_left;
        bit          stall_chk;
        bit          wq;
        int          occ;
        int          exp_done_cyc;
        bit          cmd_nonzero;
        logic [35:0] eb;
        req_served = 0; rst_served = 0; rst_check = 1; presenting = 0;
        snap_addr = '0; snap_bc = '0; stall = 0; hold_left = 0; stall_chk = 0;
        occ = 0; exp_done_cyc = -1; cmd_nonzero = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_seq != rst_served) begin
                rst_served = rst_seq;
                sys_rst = 1'b1;
                cmd_valid = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest = 1'b0;
                exp_data.delete(); exp_bursts.delete(); pending.delete();
                presenting = 0; hold_left = 0; stall_chk = 0; occ = 0;
                exp_done_cyc = -1;
                rst_check = 1;
                continue;
            end
            if (sys_rst) begin
                if (rst_check) begin
                    chk("rst_cmd_ready", 160'(cmd_ready), 160'd1);
                    chk("rst_avm", {avm_read, avm_address, avm_burstcount}, '0);
                    chk("rst_stream", {st_valid, st_data}, '0);
                    chk("rst_busy_done", {busy, done}, '0);
                end
                rst_check = 0;
                sys_rst = 1'b0;
                continue;
            end

            if (zw && (avm_read || busy)) zw_cnt++;

            if (done) begin
                chk("done_timing", 160'(cyc), 160'(exp_done_cyc));
                chk("done_busy_low", 160'(busy), 160'd0);
                done_cnt++;
                exp_done_cyc = -1;
            end else if (exp_done_cyc == cyc) begin
                chk("done_missing", 160'(done), 160'd1);
                exp_done_cyc = -1;
            end

            if (cmd_valid) begin
                cmd_valid = 1'b0;
                if (cmd_nonzero) chk("busy_after_accept", {busy, cmd_ready}, 160'b10);
            end else if (req_seq != req_served) begin
                req_served = req_seq;
                chk("cmd_ready_idle", 160'(cmd_ready), 160'd1);
                cmd_valid = 1'b1;
                cmd_addr = req_addr;
                cmd_beats = req_beats;
                cmd_nonzero = (req_beats != '0);
                model_cmd(req_addr, req_beats);
                hold_left = stall_arm ? 5 : 0;
                stall_chk = stall_arm;
                if (req_beats == '0) exp_done_cyc = cyc + 1;
            end

            // Return data for already-accepted bursts only.
            if (pending.size() > 0 && (!rdv_rand || $urandom_range(0, 9) < 7)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = word_of(pending.pop_front());
                rx_count++;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = '0;
            end

            if (avm_read) begin
                if (!presenting) begin
                    presenting = 1;
                    snap_addr = avm_address;
                    snap_bc = avm_burstcount;
                    stall = 0;
                end else begin
                    chk("wait_hold", {avm_read, avm_address, avm_burstcount}, {1'b1, snap_addr, snap_bc});
                end
                if (hold_left > 0) begin
                    wq = 1'b1;
                    hold_left--;
                end else begin
                    wq = wr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
                end
                avm_waitrequest = wq;
                if (!wq) begin
                    presenting = 0;
                    n_bursts++;
                    if (stall_chk) begin
                        chk("stall_cycles", 160'(stall), 160'd5);
                        stall_chk = 0;
                        stall_seen++;
                    end
                    if (exp_bursts.size() == 0) begin
                        chk("unexpected_burst", {avm_address, avm_burstcount}, '0);
                    end else begin
                        eb = exp_bursts.pop_front();
                        chk("burst", {avm_address, avm_burstcount}, 160'(eb));
                    end
                    for (int k = 0; k < int'(avm_burstcount); k++) pending.push_back(avm_address + 28'(k));
                    occ += int'(avm_burstcount);
                    chk("credit_bound", 160'(occ > 64), 160'd0);
                end else begin
                    stall++;
                end
            end else begin
                if (presenting) chk("read_dropped", 160'(avm_read), 160'd1);
                presenting = 0;
                avm_waitrequest = wr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end

            st_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (st_valid && st_ready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_beat", st_data, '0);
                end else begin
                    chk("stream_data", st_data, exp_data.pop_front());
                    if (exp_data.size() == 0 && exp_bursts.size() == 0) exp_done_cyc = cyc + 1;
                end
                pop_beats++;
                occ--;
            end
        end
    end

    int d0;

    task automatic issue(input logic [27:0] a, input logic [19:0] n);
        d0 = done_cnt;
        req_addr = a;
        req_beats = n;
        req_seq++;
    endtask

    task automatic wait_done(input int budget, input string name);
        int t;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (4) @(negedge clk);
        chk({name, "_done_once"}, 160'(done_cnt - d0), 160'd1);
        chk({name, "_all_streamed"}, 160'(exp_data.size()), 160'd0);
    endtask

    initial begin
        int nb0;
        int rx0;
        int p0;
        int z0;
        int s0;
        int t;
        repeat (6) @(negedge clk);

        rdy_mode = 1;
        nb0 = n_bursts;
        issue(28'h0001000, 20'd40);
        wait_done(2000, "basic");
        chk("basic_bursts", 160'(n_bursts - nb0), 160'd3);

        rdy_mode = 0;
        nb0 = n_bursts;
        issue(28'h0002000, 20'd100);
        repeat (400) @(negedge clk);
        chk("credit_bursts", 160'(n_bursts - nb0), 160'd4);
        chk("credit_read_low", {avm_read, busy}, 160'b01);
        rdy_mode = 2;
        wait_done(3000, "credit");
        chk("credit_total", 160'(n_bursts - nb0), 160'd7);

        rdy_mode = 1;
        stall_arm = 1;
        s0 = stall_seen;
        issue(28'h0200000, 20'd24);
        wait_done(2000, "stall");
        stall_arm = 0;
        chk("stall_observed", 160'(stall_seen - s0), 160'd1);

        zw = 1;
        z0 = zw_cnt;
        nb0 = n_bursts;
        issue(28'h0000055, 20'd0);
        wait_done(20, "zero");
        chk("zero_no_activity", 160'(zw_cnt - z0), 160'd0);
        chk("zero_no_bursts", 160'(n_bursts - nb0), 160'd0);
        zw = 0;

        nb0 = n_bursts;
        issue(28'hFFFFFF8, 20'd16);
        wait_done(1000, "wrap");
        chk("wrap_bursts", 160'(n_bursts - nb0), 160'd1);

        wr_rand = 1;
        rdv_rand = 1;
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            issue(28'($urandom), 20'($urandom_range(1, 150)));
            wait_done(4000, "random");
        end

        wr_rand = 0;
        rdv_rand = 0;
        rdy_mode = 0;
        rx0 = rx_count;
        issue(28'h0003000, 20'd40);
        t = 0;
        while (rx_count - rx0 < 20 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_rx_reached", 160'(rx_count - rx0 >= 20), 160'd1);
        rst_seq++;
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        p0 = pop_beats;
        issue(28'h0004000, 20'd8);
        wait_done(1000, "after_rst");
        chk("after_rst_beats", 160'(pop_beats - p0), 160'd8);
`ifdef SDRAM_RD_PERF_EN
        chk("perf_beats", 160'(perf_beats), 160'd8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
